// File: rtl/atm_txn_arbiter.sv
// Round-robin transaction controller: N_TERM ATM terminals share one 10-entry
// account/PIN/balance ledger, with a login session and lockout count per terminal.
module atm_txn_arbiter #(
    parameter int N_TERM = 4,
    parameter int BAL_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_TERM-1:0]       req,
    input  logic [3*N_TERM-1:0]     req_op,
    input  logic [12*N_TERM-1:0]    req_acc,
    input  logic [4*N_TERM-1:0]     req_pin,
    input  logic [BAL_W*N_TERM-1:0] req_amt,
    output logic [N_TERM-1:0]       gnt,
    output logic [N_TERM-1:0]       done,
    output logic [1:0]              rsp_status,
    output logic [BAL_W-1:0]        rsp_balance,
    output logic                    busy
);
    localparam int TW    = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam int N_ACC = 10;

    localparam logic [2:0] OP_LOGIN    = 3'b001;
    localparam logic [2:0] OP_BALANCE  = 3'b011;
    localparam logic [2:0] OP_WITHDRAW = 3'b100;
    localparam logic [2:0] OP_DEPOSIT  = 3'b101;
    localparam logic [2:0] OP_LOGOUT   = 3'b110;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_BAD_CRED = 2'b01;
    localparam logic [1:0] ST_REFUSED  = 2'b10;
    localparam logic [1:0] ST_BAD_OP   = 2'b11;

    typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_t;
    state_t state, state_next;

    logic [TW-1:0]    ptr, cur, pick;
    logic             any_req;
    logic [2:0]       cap_op, pick_op;
    logic [11:0]      cap_acc;
    logic [3:0]       cap_pin;
    logic [BAL_W-1:0] cap_amt;
    logic [3:0]       k;
    logic [BAL_W-1:0] bal [N_ACC];
    logic [N_TERM-1:0] sess_valid;
    logic [3:0]       sess_idx [N_TERM];
    logic [1:0]       fail_cnt [N_TERM];

    logic             acc_hit, pin_hit;
    logic [3:0]       sidx;
    logic [BAL_W-1:0] sbal;
    logic [BAL_W:0]   dep_sum;
    logic [1:0]       ex_status;
    logic [BAL_W-1:0] ex_balance, ex_newbal;
    logic             ex_wr, ex_logout;

    // Account numbers live in a constant table; only balances are writable.
    function automatic logic [11:0] acc_of(input logic [3:0] i);
        case (i)
            4'd0:    return 12'd2749;
            4'd1:    return 12'd2175;
            4'd2:    return 12'd2429;
            4'd3:    return 12'd2125;
            4'd4:    return 12'd2178;
            4'd5:    return 12'd2647;
            4'd6:    return 12'd2816;
            4'd7:    return 12'd2910;
            4'd8:    return 12'd2299;
            4'd9:    return 12'd2689;
            default: return 12'd0;
        endcase
    endfunction

    function automatic logic [BAL_W-1:0] bal_init(input logic [3:0] i);
        case (i)
            4'd0:    return BAL_W'(5000);
            4'd1:    return BAL_W'(10000);
            4'd2:    return BAL_W'(6500);
            4'd3:    return BAL_W'(4000);
            4'd4:    return BAL_W'(40000);
            4'd5:    return BAL_W'(550);
            4'd6:    return BAL_W'(400);
            4'd7:    return BAL_W'(620);
            4'd8:    return BAL_W'(8800);
            4'd9:    return BAL_W'(7200);
            default: return '0;
        endcase
    endfunction

    function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] base, input int j);
        int t;
        t = (int'(base) + j) % N_TERM;
        return TW'(t);
    endfunction

    // Scan from lowest to highest priority so the highest-priority requester wins.
    always_comb begin
        any_req = 1'b0;
        pick    = ptr;
        for (int j = N_TERM - 1; j >= 0; j--) begin
            if (req[rr_idx(ptr, j)]) begin
                any_req = 1'b1;
                pick    = rr_idx(ptr, j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pick_op    = req_op[3*pick +: 3];
        acc_hit    = (acc_of(k) == cap_acc);
        pin_hit    = (k == cap_pin);
        sidx       = sess_idx[cur];
        sbal       = bal[sidx];
        dep_sum    = {1'b0, sbal} + {1'b0, cap_amt};
        ex_status  = ST_OK;
        ex_balance = '0;
        ex_newbal  = sbal;
        ex_wr      = 1'b0;
        ex_logout  = 1'b0;

        case (state)
            IDLE:    if (any_req)
                         state_next = (pick_op == OP_LOGIN && fail_cnt[pick] != 2'd3) ? LOOKUP : EXEC;
            LOOKUP:  if (acc_hit || k == 4'd9) state_next = RESP;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // A LOGIN only reaches EXEC when the terminal is locked out.
        case (cap_op)
            OP_LOGIN:    ex_status = ST_REFUSED;
            OP_BALANCE:  if (!sess_valid[cur]) ex_status = ST_REFUSED;
                         else                  ex_balance = sbal;
            OP_WITHDRAW: if (!sess_valid[cur]) ex_status = ST_REFUSED;
                         else if (cap_amt <= sbal) begin
                             ex_newbal  = sbal - cap_amt;
                             ex_wr      = 1'b1;
                             ex_balance = ex_newbal;
                         end else begin
                             ex_status  = ST_REFUSED;
                             ex_balance = sbal;
                         end
            OP_DEPOSIT:  if (!sess_valid[cur]) ex_status = ST_REFUSED;
                         else if (cap_amt >= BAL_W'(100) && cap_amt <= BAL_W'(10000) && !dep_sum[BAL_W]) begin
                             ex_newbal  = dep_sum[BAL_W-1:0];
                             ex_wr      = 1'b1;
                             ex_balance = ex_newbal;
                         end else begin
                             ex_status  = ST_REFUSED;
                             ex_balance = sbal;
                         end
            OP_LOGOUT:   ex_logout = 1'b1;
            default:     ex_status = ST_BAD_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            cur         <= '0;
            cap_op      <= '0;
            cap_acc     <= '0;
            cap_pin     <= '0;
            cap_amt     <= '0;
            k           <= '0;
            gnt         <= '0;
            rsp_status  <= ST_OK;
            rsp_balance <= '0;
            sess_valid  <= '0;
            for (int i = 0; i < N_TERM; i++) begin
                sess_idx[i] <= '0;
                fail_cnt[i] <= '0;
            end
            for (int i = 0; i < N_ACC; i++) bal[i] <= bal_init(4'(i));
        end else begin
            gnt <= '0;
            case (state)
                IDLE: if (any_req) begin
                    cur     <= pick;
                    ptr     <= rr_idx(pick, 1);
                    gnt     <= N_TERM'(1) << pick;
                    cap_op  <= pick_op;
                    cap_acc <= req_acc[12*pick +: 12];
                    cap_pin <= req_pin[4*pick +: 4];
                    cap_amt <= req_amt[BAL_W*pick +: BAL_W];
                    k       <= '0;
                end
                LOOKUP: begin
                    k <= k + 4'd1;
                    if (acc_hit && pin_hit) begin
                        sess_valid[cur] <= 1'b1;
                        sess_idx[cur]   <= k;
                        fail_cnt[cur]   <= '0;
                        rsp_status      <= ST_OK;
                        rsp_balance     <= bal[k];
                    end else if (acc_hit || k == 4'd9) begin
                        sess_valid[cur] <= 1'b0;
                        if (fail_cnt[cur] != 2'd3) fail_cnt[cur] <= fail_cnt[cur] + 2'd1;
                        rsp_status      <= ST_BAD_CRED;
                        rsp_balance     <= '0;
                    end
                end
                EXEC: begin
                    rsp_status  <= ex_status;
                    rsp_balance <= ex_balance;
                    if (ex_wr)     bal[sidx]       <= ex_newbal;
                    if (ex_logout) sess_valid[cur] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign done = (state == RESP) ? (N_TERM'(1) << cur) : '0;
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Scoreboard bench for atm_txn_arbiter: a ledger/session model predicts every
// response in grant order; a monitor compares on each gnt and done pulse.
`timescale 1ns/1ps
module tb_atm_txn_arbiter;
    localparam int N  = 4;
    localparam int BW = 16;
    localparam int S_OK = 0, S_CRED = 1, S_REF = 2, S_BADOP = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [3*N-1:0]  req_op = '0;
    logic [12*N-1:0] req_acc = '0;
    logic [4*N-1:0]  req_pin = '0;
    logic [BW*N-1:0] req_amt = '0;
    logic [N-1:0]  gnt, done;
    logic [1:0]    rsp_status;
    logic [BW-1:0] rsp_balance;
    logic          busy;

    atm_txn_arbiter #(.N_TERM(N), .BAL_W(BW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_acc(req_acc),
        .req_pin(req_pin), .req_amt(req_amt), .gnt(gnt), .done(done),
        .rsp_status(rsp_status), .rsp_balance(rsp_balance), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int term; int st; int bal; int lat; } exp_t;
    exp_t exp_q[$];
    int n_chk = 0, n_fail = 0, n_done = 0, gnt_cyc = 0;

    task automatic check(input string name, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference model: ledger table, sessions, lockout counts, arbitration pointer.
    int acc_t [10] = '{2749, 2175, 2429, 2125, 2178, 2647, 2816, 2910, 2299, 2689};
    int bal_t [10] = '{5000, 10000, 6500, 4000, 40000, 550, 400, 620, 8800, 7200};
    int m_bal [10];
    bit m_sv [N];
    int m_si [N];
    int m_fc [N];
    int m_ptr;

    task automatic model_reset();
        m_bal = bal_t;
        for (int i = 0; i < N; i++) begin
            m_sv[i] = 0; m_si[i] = 0; m_fc[i] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic model_txn(input int t, input int op, input int acc, input int pin, input int amt,
                             output int st, output int bal, output int lat);
        int found;
        st = S_OK; bal = 0; lat = 1;
        case (op)
            1: if (m_fc[t] == 3) st = S_REF;
               else begin
                   found = -1;
                   for (int j = 0; j < 10; j++) if (found < 0 && acc_t[j] == acc) found = j;
                   lat = (found >= 0) ? found + 1 : 10;
                   if (found >= 0 && pin == found) begin
                       m_sv[t] = 1; m_si[t] = found; m_fc[t] = 0; bal = m_bal[found];
                   end else begin
                       st = S_CRED; m_sv[t] = 0;
                       if (m_fc[t] < 3) m_fc[t]++;
                   end
               end
            3: if (!m_sv[t]) st = S_REF; else bal = m_bal[m_si[t]];
            4: if (!m_sv[t]) st = S_REF;
               else if (amt <= m_bal[m_si[t]]) begin
                   m_bal[m_si[t]] -= amt; bal = m_bal[m_si[t]];
               end else begin
                   st = S_REF; bal = m_bal[m_si[t]];
               end
            5: if (!m_sv[t]) st = S_REF;
               else if (amt >= 100 && amt <= 10000 && m_bal[m_si[t]] + amt < 65536) begin
                   m_bal[m_si[t]] += amt; bal = m_bal[m_si[t]];
               end else begin
                   st = S_REF; bal = m_bal[m_si[t]];
               end
            6: m_sv[t] = 0;
            default: st = S_BADOP;
        endcase
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                if (exp_q.size() == 0) check("gnt_unexpected", int'(gnt), 0);
                else begin
                    check("gnt_term", int'(gnt), 1 << exp_q[0].term);
                    check("busy_at_gnt", int'(busy), 1);
                    gnt_cyc = cyc;
                end
            end
            if (done != '0) begin
                n_done++;
                if (exp_q.size() == 0) check("done_unexpected", int'(done), 0);
                else begin
                    e = exp_q.pop_front();
                    check("done_term", int'(done), 1 << e.term);
                    check("rsp_status", int'(rsp_status), e.st);
                    check("rsp_balance", int'(rsp_balance), e.bal);
                    check("done_latency", cyc - gnt_cyc, e.lat);
                end
            end
        end
    end

    int b_op [N], b_acc [N], b_pin [N], b_amt [N];

    task automatic apply_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_done", int'(done), 0);
        check("rst_status", int'(rsp_status), 0);
        check("rst_balance", int'(rsp_balance), 0);
        check("rst_busy", int'(busy), 0);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 300;
        while (req != '0 && budget > 0) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (done[i]) req[i] = 1'b0;
            budget--;
        end
        @(negedge clk);
        if (req != '0) begin
            check("drain_timeout", int'(req), 0);
            apply_reset();
        end
    endtask

    task automatic issue(input logic [N-1:0] mask);
        logic [N-1:0] left;
        exp_t e;
        int t, st, bl, lt;
        left = mask;
        while (left != '0) begin
            t = -1;
            for (int j = 0; j < N; j++) if (t < 0 && left[(m_ptr + j) % N]) t = (m_ptr + j) % N;
            left[t] = 1'b0;
            m_ptr = (t + 1) % N;
            model_txn(t, b_op[t], b_acc[t], b_pin[t], b_amt[t], st, bl, lt);
            e.term = t; e.st = st; e.bal = bl; e.lat = lt;
            exp_q.push_back(e);
        end
        for (int i = 0; i < N; i++) if (mask[i]) begin
            req_op[3*i +: 3]   = 3'(b_op[i]);
            req_acc[12*i +: 12] = 12'(b_acc[i]);
            req_pin[4*i +: 4]  = 4'(b_pin[i]);
            req_amt[BW*i +: BW] = BW'(b_amt[i]);
        end
        req = req | mask;
        wait_drain();
    endtask

    task automatic one(input int t, input int op, input int acc, input int pin, input int amt);
        b_op[t] = op; b_acc[t] = acc; b_pin[t] = pin; b_amt[t] = amt;
        issue(N'(1) << t);
    endtask

    // Reset asserted in the grant cycle of a WITHDRAW must drop it without a done or a write.
    task automatic abort_test();
        exp_t e;
        int budget, d0;
        e.term = 1; e.st = 0; e.bal = 0; e.lat = 1;
        exp_q.push_back(e);
        req_op[3 +: 3]   = 3'd4;
        req_amt[BW +: BW] = BW'(100);
        req[1] = 1'b1;
        budget = 20;
        do begin
            @(negedge clk);
            budget--;
        end while (gnt[1] == 1'b0 && budget > 0);
        check("abort_gnt_seen", int'(gnt[1]), 1);
        rst_n = 1'b0;
        req = '0;
        d0 = n_done;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_reset();
        repeat (12) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        one(1, 1, 2647, 5, 0);
    endtask

    task automatic random_phase();
        logic [N-1:0] mask;
        int idx, sel;
        for (int b = 0; b < 70; b++) begin
            if (b % 15 == 0) apply_reset();
            mask = N'($urandom_range(1, 15));
            for (int t = 0; t < N; t++) begin
                idx = $urandom_range(0, 9);
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1, 2: b_op[t] = 1;
                    3:       b_op[t] = 3;
                    4, 5:    b_op[t] = 4;
                    6, 7:    b_op[t] = 5;
                    8:       b_op[t] = 6;
                    default: b_op[t] = $urandom_range(0, 7);
                endcase
                b_acc[t] = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4095) : acc_t[idx];
                b_pin[t] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : idx;
                case ($urandom_range(0, 9))
                    0:       b_amt[t] = 99;
                    1:       b_amt[t] = 100;
                    2:       b_amt[t] = 10000;
                    3:       b_amt[t] = 10001;
                    4:       b_amt[t] = 65535;
                    default: b_amt[t] = $urandom_range(0, 12000);
                endcase
            end
            issue(mask);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        model_reset();
        apply_reset();

        one(0, 1, 2429, 2, 0);
        one(0, 3, 0, 0, 0);

        apply_reset();
        b_op[0] = 1; b_acc[0] = 2749; b_pin[0] = 0; b_amt[0] = 0;
        b_op[1] = 1; b_acc[1] = 2647; b_pin[1] = 5; b_amt[1] = 0;
        b_op[2] = 1; b_acc[2] = 2647; b_pin[2] = 5; b_amt[2] = 0;
        b_op[3] = 1; b_acc[3] = 2816; b_pin[3] = 6; b_amt[3] = 0;
        issue(4'b1111);
        b_op[0] = 3; b_op[2] = 3;
        issue(4'b0101);

        one(1, 4, 0, 0, 50);
        one(2, 3, 0, 0, 0);

        one(3, 4, 0, 0, 400);
        one(3, 4, 0, 0, 1);
        one(3, 3, 0, 0, 0);

        one(0, 5, 0, 0, 99);
        one(0, 5, 0, 0, 10000);
        one(0, 1, 2178, 4, 0);
        repeat (5) one(0, 5, 0, 0, 10000);

        repeat (3) one(3, 1, 2749, 5, 0);
        one(3, 1, 2749, 0, 0);
        one(3, 3, 0, 0, 0);
        one(3, 7, 0, 0, 0);

        abort_test();
        random_phase();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/atm_txn_arbiter.md
# atm_txn_arbiter

Shared transaction controller for the ATM account ledger. It accepts transaction requests from `N_TERM` ATM terminal front-ends and grants them round-robin, one at a time. For each granted request it sequences credential lookup and balance update against a single internal 10-entry account/PIN/balance store. It keeps a login session and a failed-login lockout counter per terminal, so the terminals never touch the ledger directly.

## Interface
- Clocking: one clock; reset is synchronous and active-low.

Parameters:
- `N_TERM`, default 4: number of terminals.
- `BAL_W`, default 16: balance and amount width.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous active-low reset.
- `req`, in, N_TERM: per-terminal request. Held high with fields stable until that terminal's `done`.
- `req_op`, in, 3*N_TERM: opcode per terminal, terminal i at bits [3i+2:3i].
- `req_acc`, in, 12*N_TERM: account number per terminal.
- `req_pin`, in, 4*N_TERM: PIN per terminal.
- `req_amt`, in, BAL_W*N_TERM: amount per terminal.
- `gnt`, out, N_TERM: one-hot one-cycle pulse. Marks the request as captured.
- `done`, out, N_TERM: one-hot one-cycle pulse. Marks the response as valid.
- `rsp_status`, out, 2: result code. 00 OK, 01 BAD_CRED, 10 REFUSED, 11 BAD_OP.
- `rsp_balance`, out, BAL_W: balance reported with the response.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
Opcodes:
- 001 LOGIN
- 011 BALANCE
- 100 WITHDRAW
- 101 DEPOSIT
- 110 LOGOUT
- Any other code returns BAD_OP.

Ledger reset contents (index: account / PIN / balance):
- 0: 2749 / 0 / 5000
- 1: 2175 / 1 / 10000
- 2: 2429 / 2 / 6500
- 3: 2125 / 3 / 4000
- 4: 2178 / 4 / 40000
- 5: 2647 / 5 / 550
- 6: 2816 / 6 / 400
- 7: 2910 / 7 / 620
- 8: 2299 / 8 / 8800
- 9: 2689 / 9 / 7200

Per-terminal state:
- `sess_valid`: session active.
- `sess_idx`: 4-bit ledger index of the logged-in account.
- `fail_cnt`: 2-bit failed-login count, saturates at 3.

FSM states are IDLE, LOOKUP, EXEC and RESP:
- **IDLE:**
  - If any `req` is high, select terminal i round-robin and capture its fields.
  - Pulse `gnt[i]`.
  - Go to LOOKUP if the op is LOGIN and `fail_cnt<3`; otherwise go to EXEC.
- **LOOKUP:**
  - Compare ledger entry k (k=0..9) with the captured account, one entry per cycle.
  - On an account match with a PIN match: set `sess_valid`, set `sess_idx=k`, clear `fail_cnt`, status OK, report `rsp_balance`=balance[k]. Go to RESP.
  - On an account match with a PIN mismatch, or no match after k=9: status BAD_CRED, clear `sess_valid`, increment `fail_cnt`. Go to RESP.
- **EXEC** (one cycle):
  - LOGIN with `fail_cnt`=3: REFUSED.
  - BALANCE, WITHDRAW, DEPOSIT with `sess_valid`=0: REFUSED.
  - BALANCE: OK.
  - WITHDRAW: if `amt <= bal`, do `bal -= amt` and return OK; else REFUSED with no write.
  - DEPOSIT: if `100 <= amt <= 10000` and `bal+amt < 2^BAL_W`, add and return OK; else REFUSED. The sum is computed at BAL_W+1 bits, so no wrap is possible.
  - LOGOUT: clear `sess_valid`, return OK, report balance 0.
  - Bad opcode: BAD_OP.
- **RESP:** pulse `done[i]`, then go to IDLE.

Response field rules:
- `rsp_balance` is the post-op balance on OK.
- `rsp_balance` is the unchanged balance on WITHDRAW/DEPOSIT REFUSED.
- `rsp_balance` is 0 in every other case.
- `rsp_status` and `rsp_balance` hold until the next `done`.

Round-robin rules:
- The pointer resets to terminal 0.
- After a grant to i, terminal (i+1) mod N_TERM has highest priority.

Sharing rules:
- Several terminals may hold sessions on the same account.
- Their operations are serialized in grant order, and each sees the prior update.

## Timing
Reset values:
- `gnt`=0, `done`=0, `rsp_status`=00, `rsp_balance`=0, `busy`=0.
- FSM in IDLE, all sessions cleared, `fail_cnt`=0.
- Ledger reloaded with the reset contents.

Request sampling and grant:
- `req` is sampled in IDLE.
- `gnt[i]` is high in cycle G, the first cycle of LOOKUP or EXEC.

Response latency:
- Non-LOGIN ops, and LOGIN with `fail_cnt`=3: `done` in cycle G+1.
- LOGIN matching at index k: `done` in cycle G+k+1.
- LOGIN with no match: `done` in cycle G+10.

Handshake rules:
- The requester deasserts `req` in cycle D+1, where D is its `done` cycle. A `req` still high then is a new request.
- The earliest next `gnt` is cycle D+2.
- The ledger write happens at the EXEC clock edge.

Reset behaviour:
- `rst_n` low mid-transaction aborts it.
- No `done` is issued and any pending ledger write is discarded.

## Test plan
- **Basic session:** reset, then terminal 0 LOGIN 2429/2. Expect `gnt[0]` at G, `done` at G+3, OK, balance 6500. Then BALANCE returns OK/6500 with `done` one cycle after `gnt`.
- **Round-robin arbitration:** `req`=4'b1111 with all LOGIN requests pending from reset. Grant order is 0,1,2,3. Keeping `req[0]` and `req[2]` asserted after that, the next grants are 0, then 2.
- **Withdraw bounds:** logged in to account 2816 (balance 400). WITHDRAW 400 gives OK/0. A further WITHDRAW 1 gives REFUSED/0 and the ledger is unchanged.
- **Deposit bounds:**
  - Account 2749: DEPOSIT 99 gives REFUSED/5000; DEPOSIT 10000 gives OK/15000.
  - Account 2178 (40000): DEPOSIT 10000 gives OK/50000, and four more 10000 deposits give 60000, then REFUSED/60000.
- **Lockout and access control:**
  - Three LOGIN 2749/5 give BAD_CRED each time.
  - A fourth LOGIN with the correct PIN 2749/0 gives REFUSED at G+1.
  - BALANCE with no session gives REFUSED/0.
  - op 111 gives BAD_OP.
- **Shared account and reset:**
  - Terminals 1 and 2 both log in to 2647. T1 WITHDRAW 50, then T2 BALANCE gives 500.
  - Assert `rst_n` low at G of a WITHDRAW: no `done`, and balance returns to the reset value.
